// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    localparam int unsigned PS2_FRAME_BITS = 11;

    function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                   input int unsigned timeout_us);
        return clk_hz / 1_000_000 * timeout_us;
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Scancode stream handshake between the receiver and its consumer.
interface ps2_kbd_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronisers for both PS/2 lines plus a run-length deglitcher on the clock line.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic N_RESET,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_f,
    output logic data_s,
    output logic fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_f_q, clk_f_d;
    logic          fall_q, fall_d;
    logic          clk_s;

    assign clk_s = clk_sync_q[1];

    // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        cnt_d   = '0;
        clk_f_d = clk_f_q;
        fall_d  = 1'b0;
        if (clk_s != clk_f_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                clk_f_d = clk_s;
                fall_d  = ~clk_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge N_RESET) begin
        if (!N_RESET) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            cnt_q       <= '0;
            clk_f_q     <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            cnt_q       <= cnt_d;
            clk_f_q     <= clk_f_d;
            fall_q      <= fall_d;
        end
    end

    assign clk_f  = clk_f_q;
    assign data_s = data_sync_q[1];
    assign fall   = fall_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host frame receiver: frame FSM, inter-edge timeout and a FWFT scancode FIFO.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_US = 200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        N_RESET,
    input  logic                        ps2Clk,
    input  logic                        ps2Data,
    ps2_kbd_rx_if.master                rx,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned LW         = AW + 1;
    localparam int unsigned DataBits   = PS2_FRAME_BITS - 3;
    localparam int unsigned BW         = $clog2(DataBits);
    localparam int unsigned TimeoutCyc = timeout_cycles(CLK_HZ, TIMEOUT_US);
    localparam int unsigned TW         = $clog2(TimeoutCyc + 1);

    logic clk_f, data_s, fall;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .clk        (clk),
        .N_RESET    (N_RESET),
        .ps2_clk_i  (ps2Clk),
        .ps2_data_i (ps2Data),
        .clk_f      (clk_f),
        .data_s     (data_s),
        .fall       (fall)
    );

    ps2_state_t    state_q, state_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          push_req, push, pop, full, empty, clk_f_unused;

    assign clk_f_unused = clk_f;
    assign empty        = (level_q == '0);
    assign full         = (level_q == LW'(FIFO_DEPTH));
    assign pop          = ~empty & rx.rx_ready;

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        push_req     = 1'b0;
        to_cnt_d     = (state_q == IDLE || fall) ? '0 : to_cnt_q + 1'b1;
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {data_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BW'(DataBits - 1)) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_s)                 frame_err_d  = 1'b1;
                    else if (^{shift_q, par_q})  push_req     = 1'b1;
                    else                         parity_err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && to_cnt_q == TW'(TimeoutCyc - 1)) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
            to_cnt_d    = '0;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        push       = push_req & (~full | pop);
        overflow_d = push_req & full & ~pop;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rx.rx_valid = ~empty;
    assign rx.rx_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed plus randomized frames checked against a queue-based scancode model.
module tb_ps2_kbd_rx;

    localparam int unsigned FilterLen = 8;
    localparam int unsigned FifoDepth = 8;

    logic       clk = 1'b0;
    logic       N_RESET;
    logic       ps2Clk;
    logic       ps2Data;
    logic       parity_err, frame_err, overflow;
    logic [3:0] fifo_level;

    ps2_kbd_rx_if rx_if ();

    ps2_kbd_rx #(
        .CLK_HZ     (50_000_000),
        .FILTER_LEN (FilterLen),
        .TIMEOUT_US (200),
        .FIFO_DEPTH (FifoDepth)
    ) dut (
        .clk        (clk),
        .N_RESET    (N_RESET),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .rx         (rx_if),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #10 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int pe_cnt = 0, fe_cnt = 0, of_cnt = 0, multi_cnt = 0, stab_viol = 0;
    int exp_pe = 0, exp_fe = 0, exp_of = 0;
    logic [7:0] q[$];

    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;

    // Pulse counters, exclusivity and head-stability monitor.
    always @(negedge clk) begin
        #1;
        if (N_RESET === 1'b1) begin
            pe_cnt += int'(parity_err);
            fe_cnt += int'(frame_err);
            of_cnt += int'(overflow);
            if (int'(parity_err) + int'(frame_err) + int'(overflow) > 1) multi_cnt++;
            if (prev_v && !prev_r && rx_if.rx_valid && rx_if.rx_data !== prev_d) stab_viol++;
        end
        prev_v = rx_if.rx_valid;
        prev_r = rx_if.rx_ready;
        prev_d = rx_if.rx_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Bit cell of 40 clocks; data changes mid-high. Optional 3-cycle low glitch, or a
    // single-cycle pop aligned with the stop-bit push (2 sync + FILTER_LEN + 1 FSM cycle).
    task automatic send(input logic [10:0] f, input int nbits, input bit pop_at_stop,
                        input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            ps2Data = f[i];
            if (i == glitch_at) begin
                cyc(3); ps2Clk = 1'b0; cyc(3); ps2Clk = 1'b1; cyc(4);
            end else begin
                cyc(10);
            end
            ps2Clk = 1'b0;
            if (pop_at_stop && i == 10) begin
                cyc(FilterLen + 2);
                rx_if.rx_ready = 1'b1;
                cyc(1);
                rx_if.rx_ready = 1'b0;
                cyc(20 - FilterLen - 3);
            end else begin
                cyc(20);
            end
            ps2Clk = 1'b1;
            cyc(10);
        end
        ps2Data = 1'b1;
        cyc(5);
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop bit.
    task automatic frame(input logic [7:0] b, input int kind);
        send(mk(b, kind == 1, kind != 2), 11, 1'b0, -1);
        if (kind == 1)                  exp_pe++;
        else if (kind == 2)             exp_fe++;
        else if (q.size() < FifoDepth)  q.push_back(b);
        else                            exp_of++;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_level"}, 32'(fifo_level), q.size());
        chk({tag, "_valid"}, 32'(rx_if.rx_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk({tag, "_data"}, 32'(rx_if.rx_data), 32'(q[0]));
        chk({tag, "_perr"}, pe_cnt, exp_pe);
        chk({tag, "_ferr"}, fe_cnt, exp_fe);
        chk({tag, "_ovf"},  of_cnt, exp_of);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = (q.size() != 0) ? q[0] : 8'h00;
        chk({tag, "_pvalid"}, 32'(rx_if.rx_valid), 32'(q.size() != 0));
        chk({tag, "_pdata"}, 32'(rx_if.rx_data), 32'(e));
        rx_if.rx_ready = 1'b1;
        cyc(1);
        rx_if.rx_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        cyc(1);
    endtask

    initial begin
        logic [7:0] b;
        int         kind;
        N_RESET        = 1'b0;
        ps2Clk         = 1'b1;
        ps2Data        = 1'b1;
        rx_if.rx_ready = 1'b0;
        cyc(5);
        chk("rst_valid", 32'(rx_if.rx_valid), 0);
        chk("rst_data",  32'(rx_if.rx_data), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_pulses", 32'({parity_err, frame_err, overflow}), 0);
        N_RESET = 1'b1;
        cyc(FilterLen + 4);

        frame(8'h1C, 0);
        chk_state("t1");
        pop_check("t1");

        frame(8'h1C, 1);
        chk_state("t2a");
        frame(8'hF0, 0);
        chk_state("t2b");
        pop_check("t2");

        send(mk(8'hA5, 1'b0, 1'b1), 5, 1'b0, -1);
        cyc(12_500);
        exp_fe++;
        chk_state("t3a");
        frame(8'h5A, 0);
        chk_state("t3b");
        pop_check("t3");

        for (int i = 1; i <= 9; i++) frame(8'(i), 0);
        chk_state("t4");
        for (int i = 0; i < 8; i++) pop_check("t4");
        chk_state("t4e");

        for (int i = 0; i < 8; i++) frame(8'($urandom), 0);
        b = 8'($urandom);
        send(mk(b, 1'b0, 1'b1), 11, 1'b1, -1);
        void'(q.pop_front());
        q.push_back(b);
        chk_state("t5");
        for (int i = 0; i < 8; i++) pop_check("t5");

        b = 8'($urandom);
        send(mk(b, 1'b0, 1'b1), 11, 1'b0, 4);
        q.push_back(b);
        chk_state("t6g");

        send(mk(8'h3C, 1'b0, 1'b1), 4, 1'b0, -1);
        N_RESET = 1'b0;
        #2;
        q.delete();
        chk("t6r_valid", 32'(rx_if.rx_valid), 0);
        chk("t6r_data",  32'(rx_if.rx_data), 0);
        chk("t6r_level", 32'(fifo_level), 0);
        cyc(3);
        N_RESET = 1'b1;
        cyc(FilterLen + 4);
        frame(8'($urandom), 0);
        chk_state("t6n");

        for (int k = 0; k < 10; k++) begin
            kind = int'($urandom_range(0, 3));
            frame(8'($urandom), (kind < 2) ? 0 : kind - 1);
            chk_state("rnd");
            if ($urandom_range(0, 1) == 1 && q.size() != 0) pop_check("rnd");
        end
        while (q.size() != 0) pop_check("drain");
        chk_state("final");
        chk("exclusive", multi_cnt, 0);
        chk("head_stable", stab_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
